paddle_cap_emu: RTL and testbench
=================================

# paddle_cap_emu

Two-channel paddle emulator that sits directly upstream of the AY-3-8500 core's `pinLPin`/`pinRPin` inputs. Each frame it converts a player's position into a simulated RC-discharge delay. The position comes from keyboard buttons, analog joystick axes or raw paddle values. The block counts that delay down in video lines and raises the player's "capacitor discharged" flag when it expires. The chip reads that flag and places the bat vertically.

## Interface
Parameters:
- `SPEED_FAST`, 8: position step per frame when `fast`=1.
- `SPEED_SLOW`, 5: position step per frame when `fast`=0.
- `POS_RESET`, 128: position loaded on reset.

Ports (name, direction, width, meaning):
- `clk_sys` in 1: system clock (48 MHz). Single clock domain.
- `reset` in 1: synchronous, active-high.
- `hs`, `vs` in 1 each: active-high sync from the chip, already synchronous to `clk_sys`.
- `fast` in 1: selects `SPEED_FAST` or `SPEED_SLOW`.
- `p1_up`, `p1_down`, `p2_up`, `p2_down` in 1 each: button levels.
- `p1_src`, `p2_src` in 2 each: source select. 0 = buttons, 1 = analog high byte, 2 = analog low byte, 3 = paddle.
- `p1_invert`, `p2_invert` in 1 each: XOR the loaded count with 8'hFF.
- `mirror` in 1: `rp_in` follows channel 1 (practice mode).
- `analog0`, `analog1` in 16 each: signed joystick axes for channel 1 and channel 2.
- `paddle0`, `paddle1` in 8 each: unsigned paddle values.
- `lp_in`, `rp_in` out 1 each: 1 when the channel's count is 0.
- `p1_pos`, `p2_pos` out 8 each: current button-driven position.

## Operation
- Edge detect: register `hs` and `vs` each cycle. `vs_rise` = `vs & ~vs_q`. `hs_rise` = `hs & ~hs_q`.
- On `vs_rise`, each channel loads `cap` (8 bits) according to its `src`:
  - src 0: `cap <= pos ^ {8{invert}}`. The position value before this frame's update is used.
  - src 1: `cap <= {~a[15], a[14:8]} ^ {8{invert}}`.
  - src 2: `cap <= {~a[7], a[6:0]} ^ {8{invert}}`.
  - src 3: `cap <= paddle ^ {8{invert}}`.
- Position update, on `vs_rise` and only when src = 0. Let step = `fast ? SPEED_FAST : SPEED_SLOW`.
  - up: `pos <= (pos < step) ? 0 : pos - step`.
  - down: `pos <= (pos + step > 255) ? 255 : pos + step`. Compute the sum in 9 bits.
  - up and down both asserted: down wins.
- On `hs_rise` without `vs_rise`: decrement `cap` if it is nonzero. `cap` saturates at 0 and never wraps.
- Simultaneous `vs_rise` and `hs_rise`: the load wins and no decrement occurs.
- Outputs:
  - `lp_in = (cap1 == 0)`.
  - `rp_in = mirror ? (cap1 == 0) : (cap2 == 0)`.
  - Both are combinational from registered `cap`.
- Reset: `pos = POS_RESET`, `cap = 0`, edge registers = 0. Hence `lp_in = rp_in = 1`, `p1_pos = p2_pos = 128`.
- Reset asserted mid-frame aborts the countdown immediately. The first `vs_rise` seen after reset deasserts starts normal operation. `vs` already high at deassert does not produce an edge.

## Timing
- `cap` and `pos` change on the `clk_sys` edge after the cycle in which the sync rise is sampled.
- `lp_in`/`rp_in` follow `cap` in the same cycle (zero added latency).
- A loaded value N (with N>0) makes the flag rise on the N-th `hs_rise` after the load.
- A loaded value of 0 leaves the flag high for the whole frame.
- Worst-case countdown is 255 lines, less than 262 NTSC lines, so the count always expires before the next `vs_rise`.

## Configuration
- `PADDLE_ANALOG_EN` defined: all four sources are available, as described above.
- Not defined:
  - The `src` inputs are ignored and every channel behaves as src 0.
  - `analog*` and `paddle*` ports remain in the port list but are unused, and their mux logic is not compiled.

## Structure
- Package `paddle_pkg` holds:
  - enum `paddle_src_t` (`SRC_BTN`, `SRC_ANA_HI`, `SRC_ANA_LO`, `SRC_PADDLE`);
  - constants `POS_MAX` = 255 and `CAP_W` = 8.
- Sub-module `paddle_channel` holds one channel's `pos` register, `cap` register, source mux and saturation arithmetic. It is instantiated twice.
- The top level owns the sync edge detection and the `mirror` mux.

## Test plan
- Reset release, then one frame with no buttons pressed, src 0:
  - `p1_pos` = 128;
  - `lp_in` falls the cycle after `vs_rise` and rises on the 128th `hs_rise`.
- `p1_up` held, `fast`=1, starting from `pos` = 5: next `vs_rise` gives `pos` = 0 (saturates). The following frame keeps 0, and `lp_in` stays 1 all frame.
- `p2_down` held, `fast`=0, starting from `pos` = 252: `pos` becomes 255, and the next load gives `cap` = 255 (or 0 when `p2_invert`=1).
- src 1 with `analog0` = 16'h8000: `cap` loads 8'h00. With 16'h7F00: `cap` loads 8'hFF.
- `vs_rise` and `hs_rise` in the same cycle with `cap` = 3 and load value 10: `cap` = 10, not 9.
- `mirror`=1 with ch1 load 20 and ch2 load 200: `rp_in` rises on the 20th line together with `lp_in`. Reset asserted at line 10 forces both outputs to 1 on the next cycle.

Source files
------------

// File: rtl/paddle_pkg.sv
// rtl/paddle_pkg.sv - shared types, constants and saturating helpers for paddle_cap_emu
package paddle_pkg;

  localparam int CAP_W   = 8;
  localparam int POS_MAX = 255;

  typedef enum logic [1:0] {
    SRC_BTN    = 2'd0,
    SRC_ANA_HI = 2'd1,
    SRC_ANA_LO = 2'd2,
    SRC_PADDLE = 2'd3
  } paddle_src_t;

  // Move the bat up: clamp at the top of the screen instead of wrapping.
  function automatic logic [7:0] pos_step_up(input logic [7:0] pos, input logic [7:0] step);
    logic [7:0] res;
    if (pos < step) res = 8'd0;
    else            res = pos - step;
    return res;
  endfunction

  // Move the bat down: the sum is formed in 9 bits so the carry shows overflow.
  function automatic logic [7:0] pos_step_down(input logic [7:0] pos, input logic [7:0] step);
    logic [8:0] sum;
    logic [7:0] res;
    sum = {1'b0, pos} + {1'b0, step};
    if (sum > 9'(POS_MAX)) res = 8'(POS_MAX);
    else                   res = sum[7:0];
    return res;
  endfunction

endpackage

// File: rtl/paddle_channel.sv
// rtl/paddle_channel.sv - one paddle channel (position, discharge count, source mux); analog/paddle sources need PADDLE_ANALOG_EN
module paddle_channel
  import paddle_pkg::*;
#(
  parameter int SPEED_FAST = 8,
  parameter int SPEED_SLOW = 5,
  parameter int POS_RESET  = 128
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             vs_rise,
  input  logic             hs_rise,
  input  logic             fast,
  input  logic             up,
  input  logic             down,
  input  logic [1:0]       src,
  input  logic             invert,
  input  logic [15:0]      analog,
  input  logic [7:0]       paddle,
  output logic [CAP_W-1:0] cap,
  output logic [7:0]       pos
);

  logic [7:0]       step;
  logic [CAP_W-1:0] inv_mask;
  logic [CAP_W-1:0] load_val;
  logic             use_buttons;
  logic [7:0]       pos_next;

  assign step     = fast ? 8'(SPEED_FAST) : 8'(SPEED_SLOW);
  assign inv_mask = {CAP_W{invert}};

`ifdef PADDLE_ANALOG_EN
  paddle_src_t src_sel;
  assign src_sel     = paddle_src_t'(src);
  assign use_buttons = (src_sel == SRC_BTN);

  // Select the frame's discharge delay; analog bytes are offset-binary converted by flipping the sign bit.
  always_comb begin
    load_val = pos ^ inv_mask;
    case (src_sel)
      SRC_BTN:    load_val = pos ^ inv_mask;
      SRC_ANA_HI: load_val = {~analog[15], analog[14:8]} ^ inv_mask;
      SRC_ANA_LO: load_val = {~analog[7], analog[6:0]} ^ inv_mask;
      SRC_PADDLE: load_val = paddle ^ inv_mask;
      default:    load_val = pos ^ inv_mask;
    endcase
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^{src, analog, paddle};
  assign use_buttons   = 1'b1;
  assign load_val      = pos ^ inv_mask;
`endif

  // Button-driven position for next frame; down has priority when both are held.
  always_comb begin
    pos_next = pos;
    if (down)    pos_next = pos_step_down(pos, step);
    else if (up) pos_next = pos_step_up(pos, step);
  end

  // Load the count at frame start (old position), then count lines down to zero.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pos <= 8'(POS_RESET);
      cap <= '0;
    end else if (vs_rise) begin
      cap <= load_val;
      if (use_buttons) pos <= pos_next;
    end else if (hs_rise && (cap != '0)) begin
      cap <= cap - CAP_W'(1);
    end
  end

endmodule

// File: rtl/paddle_cap_emu.sv
// rtl/paddle_cap_emu.sv - two-channel AY-3-8500 paddle RC-discharge emulator; PADDLE_ANALOG_EN enables analog/paddle sources
module paddle_cap_emu
  import paddle_pkg::*;
#(
  parameter int SPEED_FAST = 8,
  parameter int SPEED_SLOW = 5,
  parameter int POS_RESET  = 128
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        hs,
  input  logic        vs,
  input  logic        fast,
  input  logic        p1_up,
  input  logic        p1_down,
  input  logic        p2_up,
  input  logic        p2_down,
  input  logic [1:0]  p1_src,
  input  logic [1:0]  p2_src,
  input  logic        p1_invert,
  input  logic        p2_invert,
  input  logic        mirror,
  input  logic [15:0] analog0,
  input  logic [15:0] analog1,
  input  logic [7:0]  paddle0,
  input  logic [7:0]  paddle1,
  output logic        lp_in,
  output logic        rp_in,
  output logic [7:0]  p1_pos,
  output logic [7:0]  p2_pos
);

  logic             hs_q;
  logic             vs_q;
  logic             rst_q;
  logic             hs_rise;
  logic             vs_rise;
  logic [CAP_W-1:0] cap1;
  logic [CAP_W-1:0] cap2;

  // Sync history; rst_q masks the first cycle after reset so a sync already high is not seen as an edge.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
      rst_q <= 1'b1;
    end else begin
      hs_q  <= hs;
      vs_q  <= vs;
      rst_q <= 1'b0;
    end
  end

  assign vs_rise = vs & ~vs_q & ~rst_q;
  assign hs_rise = hs & ~hs_q & ~rst_q;

  paddle_channel #(
    .SPEED_FAST (SPEED_FAST),
    .SPEED_SLOW (SPEED_SLOW),
    .POS_RESET  (POS_RESET)
  ) u_ch1 (
    .clk_sys (clk_sys),
    .reset   (reset),
    .vs_rise (vs_rise),
    .hs_rise (hs_rise),
    .fast    (fast),
    .up      (p1_up),
    .down    (p1_down),
    .src     (p1_src),
    .invert  (p1_invert),
    .analog  (analog0),
    .paddle  (paddle0),
    .cap     (cap1),
    .pos     (p1_pos)
  );

  paddle_channel #(
    .SPEED_FAST (SPEED_FAST),
    .SPEED_SLOW (SPEED_SLOW),
    .POS_RESET  (POS_RESET)
  ) u_ch2 (
    .clk_sys (clk_sys),
    .reset   (reset),
    .vs_rise (vs_rise),
    .hs_rise (hs_rise),
    .fast    (fast),
    .up      (p2_up),
    .down    (p2_down),
    .src     (p2_src),
    .invert  (p2_invert),
    .analog  (analog1),
    .paddle  (paddle1),
    .cap     (cap2),
    .pos     (p2_pos)
  );

  assign lp_in = (cap1 == '0);
  assign rp_in = mirror ? (cap1 == '0) : (cap2 == '0);

endmodule

// File: tb/tb_paddle_cap_emu.sv
// tb/tb_paddle_cap_emu.sv - self-checking bench for paddle_cap_emu (analog cases need PADDLE_ANALOG_EN)
module tb_paddle_cap_emu;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        hs = 1'b0, vs = 1'b0, fast = 1'b0;
  logic        p1_up = 1'b0, p1_down = 1'b0, p2_up = 1'b0, p2_down = 1'b0;
  logic [1:0]  p1_src = 2'd0, p2_src = 2'd0;
  logic        p1_invert = 1'b0, p2_invert = 1'b0, mirror = 1'b0;
  logic [15:0] analog0 = 16'h0, analog1 = 16'h0;
  logic [7:0]  paddle0 = 8'h0, paddle1 = 8'h0;
  logic        lp_in, rp_in;
  logic [7:0]  p1_pos, p2_pos;

  int total = 0;
  int bad = 0;
  logic chk_en = 1'b0;

  paddle_cap_emu dut (
    .clk_sys(clk_sys), .reset(reset), .hs(hs), .vs(vs), .fast(fast),
    .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
    .p1_src(p1_src), .p2_src(p2_src), .p1_invert(p1_invert), .p2_invert(p2_invert),
    .mirror(mirror), .analog0(analog0), .analog1(analog1),
    .paddle0(paddle0), .paddle1(paddle1),
    .lp_in(lp_in), .rp_in(rp_in), .p1_pos(p1_pos), .p2_pos(p2_pos)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A channel is described by the delay it loaded and the number of lines seen since then;
  // its flag is simply "lines seen >= delay".
  int   m_pos[2];
  int   m_delay[2];
  int   m_lines[2];
  logic m_prev_vs, m_prev_hs, m_armed;
  logic m_vr, m_hr;

  function automatic int model_delay(input int p, input logic [1:0] s, input logic inv,
                                     input logic [15:0] a, input logic [7:0] pd);
    int v;
    v = p;
`ifdef PADDLE_ANALOG_EN
    case (s)
      2'd1: v = int'($signed(a[15:8])) + 128;
      2'd2: v = int'($signed(a[7:0])) + 128;
      2'd3: v = int'(pd);
      default: v = p;
    endcase
`endif
    if (inv) v = 255 - v;
    return v;
  endfunction

  function automatic int model_move(input int p, input logic f, input logic u, input logic d);
    int st;
    st = f ? 8 : 5;
    if (d) return (p + st > 255) ? 255 : p + st;
    if (u) return (p < st) ? 0 : p - st;
    return p;
  endfunction

  function automatic logic model_uses_buttons(input logic [1:0] s);
`ifdef PADDLE_ANALOG_EN
    return s == 2'd0;
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge clk_sys) begin
    if (reset) begin
      for (int c = 0; c < 2; c++) begin
        m_pos[c] = 128; m_delay[c] = 0; m_lines[c] = 0;
      end
      m_prev_vs = 1'b0; m_prev_hs = 1'b0; m_armed = 1'b0;
    end else begin
      m_vr = vs && !m_prev_vs && m_armed;
      m_hr = hs && !m_prev_hs && m_armed;
      if (m_vr) begin
        m_delay[0] = model_delay(m_pos[0], p1_src, p1_invert, analog0, paddle0);
        m_delay[1] = model_delay(m_pos[1], p2_src, p2_invert, analog1, paddle1);
        m_lines[0] = 0; m_lines[1] = 0;
        if (model_uses_buttons(p1_src)) m_pos[0] = model_move(m_pos[0], fast, p1_up, p1_down);
        if (model_uses_buttons(p2_src)) m_pos[1] = model_move(m_pos[1], fast, p2_up, p2_down);
      end else if (m_hr) begin
        m_lines[0]++; m_lines[1]++;
      end
      m_prev_vs = vs; m_prev_hs = hs; m_armed = 1'b1;
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk_sys) begin
    if (chk_en) begin
      check("model lp_in", int'(lp_in), int'(m_lines[0] >= m_delay[0]));
      check("model rp_in", int'(rp_in),
            mirror ? int'(m_lines[0] >= m_delay[0]) : int'(m_lines[1] >= m_delay[1]));
      check("model p1_pos", int'(p1_pos), m_pos[0]);
      check("model p2_pos", int'(p2_pos), m_pos[1]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic vs_pulse(output logic l, output logic r);
    vs = 1'b1; tick(); l = lp_in; r = rp_in;
    tick(); vs = 1'b0; tick();
  endtask

  task automatic do_line(output logic l, output logic r);
    hs = 1'b1; tick(); l = lp_in; r = rp_in;
    tick(); hs = 1'b0; tick(); tick();
  endtask

  // Line number (1-based) on which the selected flag first reads 1, 0 if never within max_lines.
  task automatic lines_to_flag(input int ch, input int max_lines, output int n);
    logic l, r;
    n = 0;
    for (int i = 1; i <= max_lines; i++) begin
      do_line(l, r);
      if (((ch == 1) ? l : r) && n == 0) n = i;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic l, r;
    int   n;

    repeat (4) tick();
    chk_en = 1'b1;
    reset = 1'b0;
    tick();
    check("reset p1_pos", int'(p1_pos), 128);
    check("reset p2_pos", int'(p2_pos), 128);
    check("reset lp_in", int'(lp_in), 1);
    check("reset rp_in", int'(rp_in), 1);

    // idle frame: position 128 -> flag drops at load, rises on line 128
    vs_pulse(l, r);
    check("frame1 lp falls", int'(l), 0);
    lines_to_flag(1, 130, n);
    check("frame1 lines", n, 128);
    check("frame1 p1_pos", int'(p1_pos), 128);

    // walk ch1 up to 5 (11 fast + 7 slow steps), then saturate at 0
    p1_up = 1'b1; fast = 1'b1;
    repeat (11) vs_pulse(l, r);
    fast = 1'b0;
    repeat (7) vs_pulse(l, r);
    check("p1 reaches 5", int'(p1_pos), 5);
    fast = 1'b1;
    vs_pulse(l, r);
    check("p1 saturates 0", int'(p1_pos), 0);
    check("p1 load 5 flag", int'(l), 0);
    vs_pulse(l, r);
    check("p1 stays 0", int'(p1_pos), 0);
    check("p1 load 0 flag", int'(l), 1);
    repeat (5) do_line(l, r);
    check("p1 flag held", int'(l), 1);
    p1_up = 1'b0;

    // walk ch2 down to 252 (13 fast + 4 slow), then saturate at 255
    p2_down = 1'b1; fast = 1'b1;
    repeat (13) vs_pulse(l, r);
    fast = 1'b0;
    repeat (4) vs_pulse(l, r);
    check("p2 reaches 252", int'(p2_pos), 252);
    vs_pulse(l, r);
    check("p2 saturates 255", int'(p2_pos), 255);
    vs_pulse(l, r);
    check("p2 load 255 flag", int'(r), 0);
    lines_to_flag(2, 256, n);
    check("p2 255 lines", n, 255);
    p2_invert = 1'b1;
    vs_pulse(l, r);
    check("p2 inverted load 0", int'(r), 1);
    p2_invert = 1'b0; p2_down = 1'b0;

`ifdef PADDLE_ANALOG_EN
    p1_src = 2'd1; analog0 = 16'h8000;
    vs_pulse(l, r);
    check("ana 8000 load 0", int'(l), 1);
    analog0 = 16'h7F00;
    vs_pulse(l, r);
    lines_to_flag(1, 256, n);
    check("ana 7F00 lines", n, 255);
    p1_src = 2'd3; paddle0 = 8'd3;
    vs_pulse(l, r);
    lines_to_flag(1, 5, n);
    check("paddle 3 lines", n, 3);
    p1_src = 2'd0;
`endif

    // ch1 to position 10, count down to 3, then sync edges coincide
    p1_down = 1'b1; fast = 1'b0;
    vs_pulse(l, r);
    vs_pulse(l, r);
    p1_down = 1'b0;
    check("p1 reaches 10", int'(p1_pos), 10);
    vs_pulse(l, r);
    repeat (7) do_line(l, r);
    check("cap 3 flag low", int'(l), 0);
    vs = 1'b1; hs = 1'b1; tick();
    tick(); vs = 1'b0; hs = 1'b0; tick(); tick();
    lines_to_flag(1, 12, n);
    check("load beats decrement", n, 10);

    // ch2 255 -> 200 (5 fast + 3 slow up), ch1 10 -> 20 (2 slow down)
    p2_up = 1'b1; fast = 1'b1;
    repeat (5) vs_pulse(l, r);
    fast = 1'b0;
    repeat (3) vs_pulse(l, r);
    p2_up = 1'b0; p1_down = 1'b1;
    repeat (2) vs_pulse(l, r);
    p1_down = 1'b0;
    check("p1 reaches 20", int'(p1_pos), 20);
    check("p2 reaches 200", int'(p2_pos), 200);
    mirror = 1'b1;
    vs_pulse(l, r);
    lines_to_flag(2, 22, n);
    check("mirror rp lines", n, 20);

    // mid-frame reset at line 10
    mirror = 1'b0;
    vs_pulse(l, r);
    repeat (10) do_line(l, r);
    check("line10 lp", int'(l), 0);
    check("line10 rp", int'(r), 0);
    reset = 1'b1; tick();
    check("abort lp", int'(lp_in), 1);
    check("abort rp", int'(rp_in), 1);
    check("abort p1_pos", int'(p1_pos), 128);
    vs = 1'b1; tick();
    reset = 1'b0; tick(); tick();
    check("vs high at release", int'(lp_in), 1);
    vs = 1'b0; tick();
    vs_pulse(l, r);
    check("first frame after reset", int'(l), 0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
